// File: rtl/fetch_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_ctrl_if
// Description : Instruction-memory request bus between the fetch controller
//               (master) and the instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    // Fetch controller side: issues requests, receives data/completion
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    // Memory side: observes requests, returns data/completion
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_ctrl
// Description : Instruction fetch stage controller. Drives the instruction
//               memory request, fills the IF/ID pipeline register, absorbs
//               back-pressure from decode through a one-entry hold buffer and
//               squashes/redirects the fetch path on taken branches, draining
//               an in-flight request when needed. Keeps saturating counters
//               of stall and flush cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic               stall_IFID,
    input  wire logic               flush,
    input  wire logic [31:0]        branch_target,
    fetch_stage_ctrl_if.master      imem,
    output logic      [31:0]        pc_ID,
    output logic      [31:0]        instr_ID,
    output logic                    valid_ID,
    output logic      [15:0]        stall_cycles,
    output logic      [15:0]        flush_count
);

    localparam logic [15:0] c_cnt_max = 16'hFFFF;
    localparam logic [31:0] c_pc_step = 32'd4;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] pc_id_q,     pc_id_d;
    logic [31:0] instr_id_q,  instr_id_d;
    logic        valid_id_q,  valid_id_d;
    logic [31:0] buf_pc_q,    buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] redirect_q,  redirect_d;
    logic        req_q,       req_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Next-state, datapath and counter computation (priority flush > stall > normal)
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_id_d     = pc_id_q;
        instr_id_d  = instr_id_q;
        valid_id_d  = valid_id_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        redirect_d  = redirect_q;

        // Event counters saturate rather than wrap; flush counts even under stall
        stall_cnt_d = stall_cnt_q;
        if (stall_IFID && (stall_cnt_q != c_cnt_max)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != c_cnt_max)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end

        case (state_q)
            // One idle cycle after reset; any stray imem_ready is ignored here
            ST_RST: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (flush) begin
                    instr_id_d = NOP_INSTR;
                    valid_id_d = 1'b0;
                    if (imem.imem_ready) begin
                        // Request completes now, so the redirect can take effect at once
                        pc_d = branch_target;
                    end else begin
                        // Request still outstanding: remember target, wait for it to retire
                        redirect_d = branch_target;
                        state_d    = ST_DRAIN;
                    end
                end else if (stall_IFID) begin
                    if (imem.imem_ready) begin
                        // Decode is blocked; park the returned word so it is not lost
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem.imem_rdata;
                        pc_d        = pc_q + c_pc_step;
                        state_d     = ST_HOLD;
                    end
                end else if (imem.imem_ready) begin
                    pc_id_d    = pc_q;
                    instr_id_d = imem.imem_rdata;
                    valid_id_d = 1'b1;
                    pc_d       = pc_q + c_pc_step;
                end else begin
                    instr_id_d = NOP_INSTR;
                    valid_id_d = 1'b0;
                end
            end

            // Squashed request in flight: keep the bus stable, discard its data
            ST_DRAIN: begin
                instr_id_d = NOP_INSTR;
                valid_id_d = 1'b0;
                if (imem.imem_ready) begin
                    // A flush arriving as the drain completes supersedes the stored target
                    pc_d    = flush ? branch_target : redirect_q;
                    state_d = ST_FETCH;
                end else if (flush) begin
                    redirect_d = branch_target;
                end
            end

            ST_HOLD: begin
                if (flush) begin
                    pc_d       = branch_target;
                    instr_id_d = NOP_INSTR;
                    valid_id_d = 1'b0;
                    state_d    = ST_FETCH;
                end else if (!stall_IFID) begin
                    pc_id_d    = buf_pc_q;
                    instr_id_d = buf_instr_q;
                    valid_id_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_RST;
            end
        endcase

        // Request is registered; it follows the state being entered
        req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RST;
            pc_q        <= RESET_PC;
            pc_id_q     <= RESET_PC;
            instr_id_q  <= NOP_INSTR;
            valid_id_q  <= 1'b0;
            buf_pc_q    <= 32'd0;
            buf_instr_q <= 32'd0;
            redirect_q  <= 32'd0;
            req_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_id_q     <= pc_id_d;
            instr_id_q  <= instr_id_d;
            valid_id_q  <= valid_id_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            redirect_q  <= redirect_d;
            req_q       <= req_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // pc never moves while draining, so it doubles as the pending address
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;

    assign pc_ID        = pc_id_q;
    assign instr_ID     = instr_id_q;
    assign valid_ID     = valid_id_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule
`default_nettype wire
